// File: rtl/descrambler.sv
// Per-lane PCIe Gen1/Gen2 receive descrambler: x^16+x^5+x^4+x^3+1 Galois LFSR,
// re-seeded on COM and held on SKP, one valid/ready register stage.
module descrambler #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hFFFF,
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  SKP_SYM    = 8'h1C
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_k_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    input  logic                  descramble_disable_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_k_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  locked_o
);

    typedef enum logic {
        WAIT_COM,
        LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_adv;
    logic [DATA_WIDTH-1:0] key;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  accept, is_com, is_skp, apply_key;

    assign data_ready_o = !data_valid_o || data_ready_i;
    assign accept       = data_valid_i && data_ready_o;
    assign is_com       = data_k_i && (data_i == COM_SYM);
    assign is_skp       = data_k_i && (data_i == SKP_SYM);

    // Key byte bit i is the MSB shifted out on step i of the 8-step advance.
    always_comb begin
        lfsr_adv = lfsr_q;
        key      = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            key[i]   = lfsr_adv[15];
            lfsr_adv = {lfsr_adv[14:0], 1'b0} ^ (lfsr_adv[15] ? 16'h0039 : 16'h0000);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            if (is_com)
                lfsr_d = LFSR_SEED;
            else if (!is_skp)
                lfsr_d = lfsr_adv;
        end
    end

    assign apply_key = !data_k_i && (state_q == LOCKED) && !descramble_disable_i;
    assign data_d    = data_i ^ (apply_key ? key : '0);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WAIT_COM;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Next-state logic: the only transition is the first accepted COM.
    always_comb begin
        state_d = state_q;
        if (accept && is_com)
            state_d = LOCKED;
    end

    // Output logic
    always_comb begin
        locked_o = (state_q == LOCKED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o       <= '0;
            data_k_o     <= 1'b0;
            data_valid_o <= 1'b0;
        end else if (accept) begin
            data_o       <= data_d;
            data_k_o     <= data_k_i;
            data_valid_o <= 1'b1;
        end else if (data_ready_i) begin
            data_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/descrambler.md
Name: descrambler

Overview:
- Per-lane receive-side descrambler for the PCIe Gen1/Gen2 physical layer. It is the inverse of the transmit scrambler.
- Consumes one decoded 8b/10b symbol per cycle, with a K-flag, from the lane decoder/deskew stage. Passes descrambled symbols to the ordered-set/framing logic.
- Implements the x^16+x^5+x^4+x^3+1 LFSR with COM re-seed and SKP hold rules.
- Uses a valid/ready handshake on both sides and one pipeline register stage.

Parameters:
DATA_WIDTH, 8, symbol width; only 8 supported.
LFSR_SEED, 16'hFFFF, LFSR value loaded on reset and on every COM.
COM_SYM, 8'hBC, K28.5 symbol code.
SKP_SYM, 8'h1C, K28.0 symbol code.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; asynchronous, active-high.
data_i  input  DATA_WIDTH  received symbol.
data_k_i  input  1  1 = control (K) symbol.
data_valid_i  input  1  input symbol valid.
data_ready_o  output  1  block can accept an input symbol this cycle.
descramble_disable_i  input  1  1 = bypass: no XOR, LFSR still tracks.
data_o  output  DATA_WIDTH  descrambled symbol.
data_k_o  output  1  K-flag, delayed to match data_o.
data_valid_o  output  1  output symbol valid.
data_ready_i  input  1  downstream accepts output.
locked_o  output  1  1 once a COM has been seen since reset.

Behaviour:
- Reset (async assert, sync-released use): lfsr_q=LFSR_SEED, state=WAIT_COM, data_o=0, data_k_o=0, data_valid_o=0, locked_o=0.
- Handshake:
  - accept = data_valid_i && data_ready_o.
  - data_ready_o = !data_valid_o || data_ready_i. This is combinational and depends on the output register only.
  - Output register loads on accept. data_valid_o stays high, with data_o/data_k_o stable, until data_ready_i.
  - If data_ready_i is high and there is no accept, data_valid_o clears next cycle.
  - Latency is exactly 1 cycle input-to-output. Full throughput is 1 symbol/cycle when data_ready_i=1.
- LFSR (Galois form, advanced 8 steps per advanced symbol, bit0 first):
  - step: out_bit=lfsr[15]; lfsr = {lfsr[14:0],1'b0} ^ (lfsr[15] ? 16'h0039 : 16'h0000).
  - Key byte bit i = out_bit of step i.
- Per accepted symbol, rules in priority order:
  - K and COM_SYM: data passes unchanged; lfsr_q <= LFSR_SEED; state -> LOCKED; locked_o <= 1 on the same edge.
  - K and SKP_SYM: data passes unchanged; lfsr_q holds.
  - other K: data passes unchanged; lfsr_q advances 8 steps.
  - D symbol: data_o = data_i ^ key when state=LOCKED and descramble_disable_i=0, else data_o = data_i; lfsr_q advances 8 steps.
- WAIT_COM state: symbols are forwarded unmodified with data_valid_o asserted. The LFSR still advances per the rules above, but its value is irrelevant until the first COM.
- LOCKED state persists until reset. No other exit.
- No accept: lfsr_q, state and locked_o hold. Backpressure never corrupts LFSR alignment.
- Reset mid-stream: the output is dropped immediately (data_valid_o=0). A re-lock requires a new COM.
- descramble_disable_i is sampled on accept. Toggling it mid-stream changes only the XOR, not the LFSR sequence.

Test Plan:
1. Reset, then send K 0xBC followed by D 0xFF, D 0x17 with data_ready_i=1.
   - Outputs: K 0xBC, then D 0x00, D 0x00 at 1-cycle latency. locked_o rises with the COM.
2. COM, D 0x00, K 0x1C, D 0x00.
   - Outputs: 0xBC, 0xFF, 0x1C, 0x17. SKP does not advance the key.
3. Before any COM, send D 0x5A.
   - Output: D 0x5A unmodified, locked_o=0.
4. After COM, stream D 0x00 x4 while holding data_ready_i=0 for 3 cycles mid-stream.
   - data_o stays stable while stalled; data_ready_o=0 while stalled.
   - Output sequence: 0xFF, 0x17, 0xC0, 0x14, with no loss or duplication.
5. COM, then D 0x00 with descramble_disable_i=1, then D 0x00 with descramble_disable_i=0.
   - Outputs: 0x00, then 0x17.
6. Assert rst_i asynchronously mid-stream after lock.
   - data_valid_o and locked_o drop immediately.
   - A subsequent D 0x33 passes through as 0x33 until the next COM.
